// File: rtl/filter_pad_sequencer_pkg.sv
// Shared definitions for the filter pad sequencer: FSM state encoding,
// coordinate width and the pad-border helper.
package filter_pad_sequencer_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TOPPAD = 3'd1,
    ST_LEAD   = 3'd2,
    ST_DATA   = 3'd3,
    ST_TRAIL  = 3'd4,
    ST_BOTPAD = 3'd5,
    ST_FLUSH  = 3'd6
  } state_t;

  // Width of the padded column/row coordinates.
  localparam int COORD_W = 16;

  // Border width on each side for an odd kernel size k.
  function automatic int pad_b(input int k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/filter_pad_sequencer_raster_counter.sv
// pad_raster_counter: column/row position within the zero-padded raster.
// The column wraps at the padded row width and advances the row; at the
// final padded pixel both counters hold instead of overflowing. The
// terminal-count flags mark every boundary the sequencer FSM switches on.
module pad_raster_counter
  import filter_pad_sequencer_pkg::*;
#(
  parameter int width  = 320,
  parameter int height = 240,
  parameter int border = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               colLeadEnd,
  output logic               colDataEnd,
  output logic               colLast,
  output logic               rowTopEnd,
  output logic               rowDataEnd,
  output logic               rowLast
);

  localparam int PAD_W = width + 2 * border;
  localparam int PAD_H = height + 2 * border;

  logic [COORD_W-1:0] col_reg;
  logic [COORD_W-1:0] row_reg;

  // Advance one padded pixel per enabled cycle; hold at the frame end.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (enable && !(colLast && rowLast)) begin
      if (colLast) begin
        col_reg <= '0;
        row_reg <= row_reg + COORD_W'(1);
      end else begin
        col_reg <= col_reg + COORD_W'(1);
      end
    end
  end

  assign col        = col_reg;
  assign row        = row_reg;
  assign colLeadEnd = (col_reg == COORD_W'(border - 1));
  assign colDataEnd = (col_reg == COORD_W'(border + width - 1));
  assign colLast    = (col_reg == COORD_W'(PAD_W - 1));
  assign rowTopEnd  = (row_reg == COORD_W'(border - 1));
  assign rowDataEnd = (row_reg == COORD_W'(border + height - 1));
  assign rowLast    = (row_reg == COORD_W'(PAD_H - 1));

endmodule

// File: rtl/filter_pad_sequencer.sv
// filter_pad_sequencer: streams each frame as a zero-padded raster into the
// neighbourhood filter, then emits flush beats and pulses oDone.
// Optional feature macro: FILTER_PAD_STALL_CNT_EN (upstream stall counter on
// oStallCnt; when undefined oStallCnt is tied to zero).
// flushCycles must be at least 1.
module filter_pad_sequencer
  import filter_pad_sequencer_pkg::*;
#(
  parameter int width       = 320,
  parameter int height      = 240,
  parameter int kernelSize  = 7,
  parameter int flushCycles = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        newFrame,
  input  logic        iValid,
  input  logic [23:0] iData,
  output logic        oReady,
  output logic        oValid,
  output logic [23:0] oData,
  output logic        oPad,
  output logic [15:0] oX,
  output logic [15:0] oY,
  output logic        oBusy,
  output logic        oDone,
  output logic        oFrameErr,
  output logic [31:0] oStallCnt
);

  localparam int B       = pad_b(kernelSize);
  localparam int FLUSH_W = (flushCycles > 1) ? $clog2(flushCycles) : 1;

  state_t state_reg, state_next;

  logic [COORD_W-1:0] col, row;
  logic col_lead_end, col_data_end, col_last;
  logic row_top_end, row_data_end, row_last;

  logic [FLUSH_W-1:0] flush_cnt_reg;
  logic               flush_last;

  logic        start, cnt_en, beat, beat_pad, xy_load, done_set;
  logic [23:0] beat_data;

  logic        valid_reg, pad_reg, done_reg, done_pending_reg, frame_err_reg;
  logic [23:0] data_reg;
  logic [15:0] x_reg, y_reg;

  pad_raster_counter #(
    .width (width),
    .height(height),
    .border(B)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .enable    (cnt_en),
    .col       (col),
    .row       (row),
    .colLeadEnd(col_lead_end),
    .colDataEnd(col_data_end),
    .colLast   (col_last),
    .rowTopEnd (row_top_end),
    .rowDataEnd(row_data_end),
    .rowLast   (row_last)
  );

  assign flush_last = (flush_cnt_reg == FLUSH_W'(flushCycles - 1));
  assign oReady     = (state_reg == ST_DATA);
  assign oBusy      = (state_reg != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and beat decision for the current cycle.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    cnt_en     = 1'b0;
    beat       = 1'b0;
    beat_pad   = 1'b1;
    beat_data  = '0;
    done_set   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (newFrame) begin
          start      = 1'b1;
          state_next = ST_TOPPAD;
        end
      end
      ST_TOPPAD: begin
        beat   = 1'b1;
        cnt_en = 1'b1;
        if (col_last && row_top_end) state_next = ST_LEAD;
      end
      ST_LEAD: begin
        beat   = 1'b1;
        cnt_en = 1'b1;
        if (col_lead_end) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (iValid) begin
          beat      = 1'b1;
          beat_pad  = 1'b0;
          beat_data = iData;
          cnt_en    = 1'b1;
          if (col_data_end) state_next = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        beat   = 1'b1;
        cnt_en = 1'b1;
        if (col_last) state_next = row_data_end ? ST_BOTPAD : ST_LEAD;
      end
      ST_BOTPAD: begin
        beat   = 1'b1;
        cnt_en = 1'b1;
        if (col_last && row_last) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        beat = 1'b1;
        if (flush_last) begin
          state_next = ST_IDLE;
          done_set   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Flush beats keep the last raster coordinate on oX/oY.
  assign xy_load = beat && (state_reg != ST_FLUSH);

  // Flush beat counter, idle at zero outside FLUSH.
  always_ff @(posedge clk) begin
    if (reset || state_reg != ST_FLUSH) flush_cnt_reg <= '0;
    else                                flush_cnt_reg <= flush_cnt_reg + FLUSH_W'(1);
  end

  // Registered beat outputs and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg        <= 1'b0;
      pad_reg          <= 1'b0;
      data_reg         <= '0;
      x_reg            <= '0;
      y_reg            <= '0;
      done_pending_reg <= 1'b0;
      done_reg         <= 1'b0;
      frame_err_reg    <= 1'b0;
    end else begin
      valid_reg        <= beat;
      pad_reg          <= beat && beat_pad;
      data_reg         <= beat_data;
      if (xy_load) begin
        x_reg <= col;
        y_reg <= row;
      end
      // oDone lands on the cycle after the last flush beat is presented.
      done_pending_reg <= done_set;
      done_reg         <= done_pending_reg;
      frame_err_reg    <= newFrame && (state_reg != ST_IDLE);
    end
  end

  assign oValid    = valid_reg;
  assign oPad      = pad_reg;
  assign oData     = data_reg;
  assign oX        = x_reg;
  assign oY        = y_reg;
  assign oDone     = done_reg;
  assign oFrameErr = frame_err_reg;

`ifdef FILTER_PAD_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Count cycles where upstream offers a pixel the sequencer cannot take.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      stall_cnt_reg <= '0;
    end else if (iValid && !oReady && oBusy && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign oStallCnt = stall_cnt_reg;
`else
  assign oStallCnt = '0;
`endif

endmodule

// File: tb/tb_filter_pad_sequencer.sv
// Self-checking bench for filter_pad_sequencer (4x2 frame, 3x3 kernel, 2 flush).
// A raster reference model builds the expected beat list per frame.
module tb_filter_pad_sequencer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int K     = 3;
  localparam int FL    = 2;
  localparam int B     = (K - 1) / 2;
  localparam int PW    = W + 2 * B;
  localparam int PH    = H + 2 * B;
  localparam int BEATS = PW * PH + FL;
`ifdef FILTER_PAD_STALL_CNT_EN
  localparam int STALL_EXP = BEATS - W * H;
`else
  localparam int STALL_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, newFrame, iValid;
  logic [23:0] iData;
  logic        oReady, oValid, oPad, oBusy, oDone, oFrameErr;
  logic [23:0] oData;
  logic [15:0] oX, oY;
  logic [31:0] oStallCnt;

  filter_pad_sequencer #(
    .width(W), .height(H), .kernelSize(K), .flushCycles(FL)
  ) dut (
    .clk(clk), .reset(reset), .newFrame(newFrame), .iValid(iValid), .iData(iData),
    .oReady(oReady), .oValid(oValid), .oData(oData), .oPad(oPad), .oX(oX), .oY(oY),
    .oBusy(oBusy), .oDone(oDone), .oFrameErr(oFrameErr), .oStallCnt(oStallCnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  logic [56:0] exp_q[$];
  logic [23:0] pix_q[$];

  bit mon_en = 0;
  int cyc = 0;
  int beats_seen, ready_cycles, done_cnt, err_pulses;
  int last_beat_cyc, done_cyc, first_done_cyc, nth_cyc, target_n;
  logic [31:0] stall_at_done;
  int mode = 0;
  bit tog  = 0;

  // Reference raster: every padded pixel in raster order, then flush beats.
  task automatic queue_frame();
    logic [23:0] p;
    for (int y = 0; y < PH; y++) begin
      for (int x = 0; x < PW; x++) begin
        if (y >= B && y < B + H && x >= B && x < B + W) begin
          p = 24'($urandom);
          pix_q.push_back(p);
          exp_q.push_back({1'b0, 16'(x), 16'(y), p});
        end else begin
          exp_q.push_back({1'b1, 16'(x), 16'(y), 24'h0});
        end
      end
    end
    for (int f = 0; f < FL; f++) exp_q.push_back({1'b1, 16'(PW - 1), 16'(PH - 1), 24'h0});
  endtask

  task automatic clear_stats();
    beats_seen = 0; ready_cycles = 0; done_cnt = 0; err_pulses = 0;
    last_beat_cyc = 0; done_cyc = 0; first_done_cyc = 0; nth_cyc = 0; target_n = 0;
    stall_at_done = '0;
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [56:0] e;
    cyc++;
    if (mon_en) begin
      if (oReady) ready_cycles++;
      if (oFrameErr) err_pulses++;
      if (oDone) begin
        done_cnt++;
        done_cyc = cyc;
        if (done_cnt == 1) first_done_cyc = cyc;
        stall_at_done = oStallCnt;
      end
      if (oValid) begin
        beats_seen++;
        last_beat_cyc = cyc;
        if (beats_seen == target_n) nth_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({oPad, oX, oY, oData}), 64'(e));
        end
      end
    end
  end

  // Upstream model: holds the head pixel until it is accepted.
  task automatic set_valid();
    case (mode)
      0:       iValid = 1'b1;
      1:       begin iValid = tog; tog = !tog; end
      default: iValid = 1'($urandom_range(0, 1));
    endcase
    iData = (pix_q.size() > 0) ? pix_q[0] : 24'h0;
  endtask

  task automatic tick();
    logic acc;
    @(negedge clk);
    acc = iValid && oReady;
    @(posedge clk);
    #1;
    if (acc && pix_q.size() > 0) void'(pix_q.pop_front());
    set_valid();
  endtask

  task automatic run_frame(input int m, input int err_beat);
    bit err_sent;
    err_sent = 0;
    mode = m;
    clear_stats();
    queue_frame();
    newFrame = 1'b1;
    tick();
    newFrame = 1'b0;
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      if (err_beat >= 0 && beats_seen == err_beat && !err_sent) begin
        newFrame = 1'b1;
        err_sent = 1;
        tick();
        newFrame = 1'b0;
      end else begin
        tick();
      end
    end
    repeat (3) tick();
    check("done_pulses", 64'(done_cnt), 64'(1));
    check("beat_count", 64'(beats_seen), 64'(BEATS));
    check("exp_left", 64'(exp_q.size()), 64'(0));
    check("done_after_last", 64'(done_cyc), 64'(last_beat_cyc + 1));
    check("frame_err", 64'(err_pulses), 64'((err_beat >= 0) ? 1 : 0));
    if (m == 0) begin
      check("ready_cycles", 64'(ready_cycles), 64'(W * H));
      check("stall_cnt", 64'(stall_at_done), 64'(STALL_EXP));
    end
  endtask

  initial begin
    int saved;
    bit chained;
    reset = 1'b1; newFrame = 1'b0; iValid = 1'b0; iData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(oValid), 64'(0));
    check("rst_pad", 64'(oPad), 64'(0));
    check("rst_busy", 64'(oBusy), 64'(0));
    check("rst_done", 64'(oDone), 64'(0));
    check("rst_ferr", 64'(oFrameErr), 64'(0));
    check("rst_data", 64'(oData), 64'(0));
    check("rst_xy", 64'({oX, oY}), 64'(0));
    check("rst_stall", 64'(oStallCnt), 64'(0));
    check("rst_ready", 64'(oReady), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1;

    // Full frame with iValid held, toggling, then random valid patterns.
    run_frame(0, -1);
    run_frame(1, -1);
    repeat (3) run_frame(2, -1);

    // newFrame while busy: flagged, frame continues.
    run_frame(0, 10);

    // Reset in the middle of row 2 data.
    mode = 0;
    clear_stats();
    queue_frame();
    newFrame = 1'b1;
    tick();
    newFrame = 1'b0;
    for (int i = 0; i < 200 && beats_seen < 14; i++) tick();
    check("rst_reach", 64'(beats_seen >= 14), 64'(1));
    check("busy_mid", 64'(oBusy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    pix_q.delete();
    check("midrst_valid", 64'(oValid), 64'(0));
    check("midrst_busy", 64'(oBusy), 64'(0));
    saved = beats_seen;
    repeat (5) tick();
    check("idle_quiet", 64'(beats_seen), 64'(saved));
    run_frame(0, -1);

    // newFrame on the oDone cycle: back-to-back frames.
    mode = 0;
    clear_stats();
    target_n = BEATS + 1;
    chained = 0;
    queue_frame();
    newFrame = 1'b1;
    tick();
    newFrame = 1'b0;
    for (int i = 0; i < 400 && done_cnt < 2; i++) begin
      if (oDone && !chained) begin
        queue_frame();
        chained = 1;
        newFrame = 1'b1;
        tick();
        newFrame = 1'b0;
      end else begin
        tick();
      end
    end
    repeat (3) tick();
    check("b2b_done", 64'(done_cnt), 64'(2));
    check("b2b_beats", 64'(beats_seen), 64'(2 * BEATS));
    check("b2b_gap", 64'(nth_cyc), 64'(first_done_cyc + 2));
    check("b2b_ferr", 64'(err_pulses), 64'(0));
    check("b2b_left", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
